// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned-binary converter (reverse double-dabble, one bit per cycle).
// Optional input validation and err port enabled by defining BCD_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int NDIG = 9,
  parameter int BW   = 30
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out
`ifdef BCD_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int SW = 4*NDIG + BW;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sr, sr_nxt, sr_corr;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bin_nxt;
  logic            busy_nxt, done_nxt;
`ifdef BCD_CHECK_EN
  logic            err_nxt, bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
  end
`endif

  // One reverse double-dabble step: shift right, then pull every digit >= 8 back by 3.
  always_comb begin
    sr_corr = sr >> 1;
    for (int i = 0; i < NDIG; i++)
      if (sr_corr[BW + 4*i +: 4] >= 4'd8)
        sr_corr[BW + 4*i +: 4] = sr_corr[BW + 4*i +: 4] - 4'd3;
  end

  // NOTE: every variable gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bin_nxt   = bin_out;
`ifdef BCD_CHECK_EN
    err_nxt   = err;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef BCD_CHECK_EN
          err_nxt = 1'b0;
          if (bad_digit) begin
            state_nxt = DONE;
            bin_nxt   = '0;
            err_nxt   = 1'b1;
          end else
`endif
          begin
            sr_nxt    = {bcd_in, {BW{1'b0}}};
            cnt_nxt   = '0;
            state_nxt = CONV;
          end
        end
      end
      CONV: begin
        sr_nxt  = sr_corr;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(BW - 1)) begin
          bin_nxt   = sr_corr[BW-1:0];
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == CONV);
    done_nxt = (state_nxt == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef BCD_CHECK_EN
      err     <= 1'b0;
`endif
    end else if (enable) begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      bin_out <= bin_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef BCD_CHECK_EN
      err     <= err_nxt;
`endif
    end
  end

endmodule
